csi_packetizer: RTL
===================

Name: csi_packetizer

Overview:
- Sits directly downstream of the image-sensor pixel source and upstream of the CSI byte FIFO (CSI_FIFO_DATA_WIDTH = 8).
- Packs 14-bit RAW14 pixels into CSI-2 bytes and frames them as packets, one byte per cycle into the FIFO write port:
  - Frame Start (FS) short packet;
  - one long packet per line (header, payload, 16-bit footer);
  - Frame End (FE) short packet.

Parameters:
- LINES, IMAGE_LINES (4): lines per frame.
- LINE_PIXELS, IMAGE_LINE_PIXELS (16): pixels per line. Must be a multiple of 4; elaboration error otherwise.
- VC, VIRTUAL_CHANNEL (2'h0): virtual channel, Data Identifier (DI) bits [7:6].
- ECC_VAL, ECC (8'hCC): constant header ECC byte.
- FRAME_CNT_WIDTH, FRAME_COUNTER_WIDTH (16): frame number width, max 16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel accepted when pix_valid & pix_ready
- pix_data  in  IMAGE_PIXEL_WIDTH  pixel value
- pix_sof  in  1  marks first pixel of a frame
- fifo_full  in  1  FIFO cannot accept a write this cycle
- fifo_wr_en  out  1  byte write strobe
- fifo_wdata  out  8  byte to FIFO
- frame_busy  out  1  high from FS first byte to FE last byte
- frame_num  out  FRAME_CNT_WIDTH  number of current/last frame
- prot_err  out  1  one-cycle protocol-error pulse

Behaviour:
- Reset values:
  - pix_ready = 0, fifo_wr_en = 0, fifo_wdata = 0, frame_busy = 0, prot_err = 0, frame_num = 0.
  - All counters and buffers cleared; FSM in IDLE.
  - Reset mid-frame discards the partial frame. The next FS carries frame number 1.
- Pixel gather:
  - 4-entry gather register.
  - pix_ready = (gather count < 4) & (line pixel count < LINE_PIXELS).
  - A full gather group moves to a 7-byte output shifter when the shifter is empty. Both can hold data together, giving 1 group of lookahead.
- RAW14 packing of pixels P1..P4, in output order:
  - P1[13:6], P2[13:6], P3[13:6], P4[13:6];
  - {P2[1:0],P1[5:0]};
  - {P3[3:0],P2[5:2]};
  - {P4[5:0],P3[5:4]}.
- Word count: WC = LINE_PIXELS*14/8. Default is 28.
- FSM states and transitions:
  - IDLE: accepted pixel with pix_sof: frame_num increments, going 0 to 1, and the maximum value wraps to 1 (never 0). Go to FS.
    - Accepted pixel without pix_sof: pixel dropped, prot_err pulses, stay in IDLE.
  - FS: emit 4 bytes {VC,6'h00}, frame_num[7:0], frame_num[15:8] (zero-extended), ECC_VAL. Go to LH.
  - LH: emit {VC,6'h2D}, WC[7:0], WC[15:8], ECC_VAL. Go to PL.
  - PL: emit WC payload bytes from the shifter. Go to FT.
  - FT: emit footer low byte, then high byte.
    - If line count < LINES, go to LH.
    - Otherwise go to FE.
  - FE: emit {VC,6'h01}, frame_num lo, frame_num hi, ECC_VAL. Go to IDLE.
- pix_sof on any pixel other than the first of a frame: flag ignored, pixel used as data, prot_err pulses.
- Byte handshake:
  - fifo_wr_en = byte_pending & ~fifo_full. This is the only combinational path through the block.
  - fifo_wdata stays stable while the byte is pending. The FSM advances only on a write.
  - fifo_full held high: output stalls indefinitely with no byte loss or duplication. pix_ready deasserts once the buffers are full.
- Latency: with the FIFO never full, the first FS byte is written in cycle N+1 after the pix_sof accept in cycle N.
- Throughput: one byte per cycle; no idle cycles between packets of a frame when pixels are available.

Optional Feature:
- Macro: CSI_PKT_CRC_EN.
- Defined:
  - Footer is the CSI-2 CRC-16 (x^16+x^12+x^5+1, reflected 0x8408, init 0xFFFF, LSB-first) over the payload bytes only.
  - Output order: low byte, then high byte.
  - CRC register is re-initialised at every LH.
- Undefined: footer is 16'h0000 and no CRC logic is built.

Decomposition:
- csi_param_pkg gains:
  - packetizer state enum csi_pkt_state_t;
  - DT constants (already present);
  - localparam function for WC.
- Sub-module csi_crc16: byte-wide CRC-16 update with init and enable, instantiated only under CSI_PKT_CRC_EN.

Test Plan:
- One frame, fifo_full = 0, 4x16 pixels:
  - bytes 00,01,00,CC;
  - then per line 2D,1C,00,CC + 28 payload + 2 footer;
  - then 01,01,00,CC;
  - 4*34 + 8 = 144 writes total.
- Packing: P1..P4 = 3FFF,0000,2AAA,1555 -> payload bytes FF,00,AA,55,3F,A0,56.
- Backpressure: fifo_full toggled randomly 50% over 3 frames -> byte stream identical to the stall-free run; pix_ready drops while stalled.
- Frame counter wrap with FRAME_CNT_WIDTH = 2: FS frame numbers over 5 frames are 1,2,3,1,2.
- Errors:
  - pixel without pix_sof in IDLE -> prot_err pulse, no FIFO write;
  - mid-frame pix_sof -> prot_err pulse, frame completes normally.
- Reset mid-line (after 10 payload bytes), then a new frame -> first bytes 00,01,00,CC.
- With CSI_PKT_CRC_EN: footers match the bench bit-serial CRC model.

Source files
------------

// File: rtl/csi_param_pkg.sv
// Shared CSI-2 constants, packetizer state type and word-count helper.
// Used by csi_packetizer and csi_crc16.
package csi_param_pkg;

    localparam int IMAGE_PIXEL_WIDTH   = 14;
    localparam int CSI_FIFO_DATA_WIDTH = 8;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW14 = 6'h2D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FS,
        ST_LH,
        ST_PL,
        ST_FT,
        ST_FE
    } csi_pkt_state_t;

    // RAW14 long-packet payload length in bytes for a line of the given width
    function automatic logic [15:0] wc_calc(input int pixels);
        return 16'((pixels * 14) / 8);
    endfunction

endpackage

// File: rtl/csi_crc16.sv
// Byte-wide CSI-2 CRC-16 (poly 0x8408 reflected, init 0xFFFF, LSB first).
// Only instantiated when CSI_PKT_CRC_EN is defined.
module csi_crc16
    import csi_param_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           init,
    input  logic                           en,
    input  logic [CSI_FIFO_DATA_WIDTH-1:0] data,
    output logic [15:0]                    crc
);

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     crc <= 16'hFFFF;
        else if (init)  crc <= 16'hFFFF;
        else if (en)    crc <= crc_byte(crc, data);
    end

endmodule

// File: rtl/csi_packetizer.sv
// RAW14 pixel packer and CSI-2 frame/line packetizer feeding a byte FIFO.
// Define CSI_PKT_CRC_EN to emit a real CRC-16 footer instead of 16'h0000.
//
// state | meaning
// IDLE  | waiting for a pix_sof pixel; stray pixels dropped with prot_err
// FS    | frame start short packet (4 bytes)
// LH    | long packet header for one line (4 bytes)
// PL    | WC payload bytes drained from the shifter
// FT    | 16-bit footer, low byte first
// FE    | frame end short packet (4 bytes)
module csi_packetizer
    import csi_param_pkg::*;
#(
    parameter int         LINES           = 4,
    parameter int         LINE_PIXELS     = 16,
    parameter logic [1:0] VC              = 2'h0,
    parameter logic [7:0] ECC_VAL         = 8'hCC,
    parameter int         FRAME_CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           pix_valid,
    output logic                           pix_ready,
    input  logic [IMAGE_PIXEL_WIDTH-1:0]   pix_data,
    input  logic                           pix_sof,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [CSI_FIFO_DATA_WIDTH-1:0] fifo_wdata,
    output logic                           frame_busy,
    output logic [FRAME_CNT_WIDTH-1:0]     frame_num,
    output logic                           prot_err
);

    localparam logic [15:0] WC    = wc_calc(LINE_PIXELS);
    localparam int          LPC_W = $clog2(LINE_PIXELS + 1);
    localparam int          LC_W  = $clog2(LINES + 1);

    if (LINE_PIXELS % 4 != 0) begin : g_lp_chk
        $error("csi_packetizer: LINE_PIXELS must be a multiple of 4");
    end
    if (FRAME_CNT_WIDTH > 16 || FRAME_CNT_WIDTH < 1) begin : g_fc_chk
        $error("csi_packetizer: FRAME_CNT_WIDTH must be 1..16");
    end

    csi_pkt_state_t state, state_nxt;

    logic                         ready_en;
    logic [IMAGE_PIXEL_WIDTH-1:0] gath [4];
    logic [2:0]                   gcnt;
    logic [55:0]                  shf;
    logic [2:0]                   scnt;
    logic [LPC_W-1:0]             lpc;
    logic [LC_W-1:0]              lcnt;
    logic [15:0]                  pcnt;
    logic [1:0]                   bidx;
    logic [15:0]                  fn16;
    logic [15:0]                  footer;
    logic [7:0]                   byte_mux;
    logic                         byte_pending;
    logic                         wr, pay_wr, pay_end, more_lines;
    logic                         accept, store, sof_start, sh_load, hdr_last;

    function automatic logic [55:0] pack4(input logic [13:0] p1, input logic [13:0] p2,
                                          input logic [13:0] p3, input logic [13:0] p4);
        return {p4[5:0], p3[5:4], p3[3:0], p2[5:2], p2[1:0], p1[5:0],
                p4[13:6], p3[13:6], p2[13:6], p1[13:6]};
    endfunction

    assign fn16       = 16'(frame_num);
    assign pix_ready  = ready_en && (gcnt < 3'd4) && (lpc < LPC_W'(LINE_PIXELS));
    assign accept     = pix_valid && pix_ready;
    assign sof_start  = accept && pix_sof && (state == ST_IDLE);
    // pixels in IDLE without pix_sof are dropped rather than gathered
    assign store      = accept && ((state != ST_IDLE) || pix_sof);
    assign wr         = byte_pending && !fifo_full;
    assign pay_wr     = wr && (state == ST_PL);
    assign pay_end    = pay_wr && (pcnt == WC - 16'd1);
    assign hdr_last   = wr && (bidx == 2'd3);
    assign more_lines = lcnt < LC_W'(LINES);
    // refill on the same edge the last shifter byte leaves to avoid a bubble
    assign sh_load    = (gcnt == 3'd4) && ((scnt == 3'd0) || ((scnt == 3'd1) && pay_wr));

    assign fifo_wr_en = wr;
    assign fifo_wdata = byte_mux;
    assign frame_busy = (state != ST_IDLE);

`ifdef CSI_PKT_CRC_EN
    logic crc_init;
    assign crc_init = (state == ST_LH);
    csi_crc16 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (crc_init),
        .en    (pay_wr),
        .data  (shf[7:0]),
        .crc   (footer)
    );
`else
    assign footer = 16'h0000;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sof_start)         state_nxt = ST_FS;
            ST_FS:   if (hdr_last)          state_nxt = ST_LH;
            ST_LH:   if (hdr_last)          state_nxt = ST_PL;
            ST_PL:   if (pay_end)           state_nxt = ST_FT;
            ST_FT:   if (wr && bidx[0])     state_nxt = more_lines ? ST_LH : ST_FE;
            ST_FE:   if (hdr_last)          state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_pending = 1'b0;
        byte_mux     = 8'h00;
        case (state)
            ST_FS, ST_FE: begin
                byte_pending = 1'b1;
                case (bidx)
                    2'd0:    byte_mux = {VC, (state == ST_FS) ? DT_FS : DT_FE};
                    2'd1:    byte_mux = fn16[7:0];
                    2'd2:    byte_mux = fn16[15:8];
                    default: byte_mux = ECC_VAL;
                endcase
            end
            ST_LH: begin
                byte_pending = 1'b1;
                case (bidx)
                    2'd0:    byte_mux = {VC, DT_RAW14};
                    2'd1:    byte_mux = WC[7:0];
                    2'd2:    byte_mux = WC[15:8];
                    default: byte_mux = ECC_VAL;
                endcase
            end
            ST_PL: begin
                byte_pending = (scnt != 3'd0);
                byte_mux     = shf[7:0];
            end
            ST_FT: begin
                byte_pending = 1'b1;
                byte_mux     = bidx[0] ? footer[15:8] : footer[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            gcnt      <= 3'd0;
            shf       <= 56'd0;
            scnt      <= 3'd0;
            lpc       <= '0;
            lcnt      <= '0;
            pcnt      <= 16'd0;
            bidx      <= 2'd0;
            frame_num <= '0;
            prot_err  <= 1'b0;
            for (int i = 0; i < 4; i++) gath[i] <= '0;
        end else begin
            ready_en <= 1'b1;
            prot_err <= accept && (pix_sof == (state != ST_IDLE));

            if (sh_load) begin
                gcnt <= 3'd0;
                shf  <= pack4(gath[0], gath[1], gath[2], gath[3]);
                scnt <= 3'd7;
            end else begin
                if (store) begin
                    gath[gcnt[1:0]] <= pix_data;
                    gcnt            <= gcnt + 3'd1;
                end
                if (pay_wr) begin
                    shf  <= shf >> 8;
                    scnt <= scnt - 3'd1;
                end
            end

            if ((state == ST_FE) && hdr_last)  lpc <= '0;
            else if (pay_end && more_lines)    lpc <= '0;
            else if (store)                    lpc <= lpc + 1'b1;

            if (state == ST_FS)                     lcnt <= '0;
            else if ((state == ST_LH) && hdr_last)  lcnt <= lcnt + 1'b1;

            if (state == ST_LH)  pcnt <= 16'd0;
            else if (pay_wr)     pcnt <= pcnt + 16'd1;

            if (state_nxt != state)            bidx <= 2'd0;
            else if (wr && state != ST_PL)     bidx <= bidx + 2'd1;

            if (sof_start) begin
                if (frame_num == {FRAME_CNT_WIDTH{1'b1}}) frame_num <= FRAME_CNT_WIDTH'(1);
                else                                     frame_num <= frame_num + 1'b1;
            end
        end
    end

endmodule
